// File: rtl/io_int_pkg.sv
// ---------------------------------------------------------------------------
// io_int_pkg
// Shared definitions for the I/O and interrupt controller slice.
//   - channel state encodings (chosen so the state bit equals the flag value)
//   - interrupt FSM state encoding
//   - flag reset constants
// ---------------------------------------------------------------------------
package io_int_pkg;

   // Flag values coming out of reset: no input word waiting, output free.
   localparam logic FGI_RST = 1'b0;
   localparam logic FGO_RST = 1'b1;

   // Input channel: the encoding equals fgi, so the flag is a pure state decode.
   typedef enum logic {
      IN_EMPTY = 1'b0,
      IN_FULL  = 1'b1
   } in_state_t;

   // Output channel: the encoding equals fgo (idle means the flag is set).
   typedef enum logic {
      OUT_BUSY = 1'b0,
      OUT_IDLE = 1'b1
   } out_state_t;

   // Interrupt request sequencing.
   typedef enum logic [1:0] {
      INT_OFF     = 2'd0,
      INT_ARMED   = 2'd1,
      INT_PENDING = 2'd2
   } int_state_t;

endpackage

// File: rtl/int_req_fsm.sv
// ---------------------------------------------------------------------------
// int_req_fsm
// Three-state interrupt request FSM (OFF / ARMED / PENDING).
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   ion, iof     interrupt enable / disable strobes
//   ack          interrupt cycle completed
//   boundary     T0 slot before the next fetch
//   flag_any     registered fgi | fgo
//   ien          interrupt enable (registered)
//   int_r        interrupt-cycle request R (registered)
// ---------------------------------------------------------------------------
module int_req_fsm
   import io_int_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic ion,
   input  logic iof,
   input  logic ack,
   input  logic boundary,
   input  logic flag_any,
   output logic ien,
   output logic int_r
);

   int_state_t state;

   // State and both outputs are registered together. An acknowledge or an IOF
   // always wins and drops straight to OFF, which is why ack+iof in the same
   // cycle cannot leave the request armed. ION only matters from OFF, and a
   // boundary only raises R from ARMED when a flag was already set before the
   // edge (flag_any is itself a register decode).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INT_OFF;
         ien   <= 1'b0;
         int_r <= 1'b0;
      end else if (ack || iof) begin
         state <= INT_OFF;
         ien   <= 1'b0;
         int_r <= 1'b0;
      end else begin
         case (state)
            INT_OFF: begin
               if (ion) begin
                  state <= INT_ARMED;
                  ien   <= 1'b1;
               end
            end
            INT_ARMED: begin
               if (boundary && flag_any) begin
                  state <= INT_PENDING;
                  int_r <= 1'b1;
               end
            end
            INT_PENDING: begin
               state <= INT_PENDING;
            end
            default: begin
               state <= INT_OFF;
               ien   <= 1'b0;
               int_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/io_int_ctrl.sv
// ---------------------------------------------------------------------------
// io_int_ctrl
// I/O datapath sequencer: fills INPR from the input device, drains OUTR to
// the output device, keeps FGI/FGO/IEN and raises the interrupt request R.
// Ports:
//   clk, reset                       clock, async active-high reset
//   dev_in_valid/data, dev_in_ready  input device handshake
//   dev_out_valid, dev_out_ready     output device handshake
//   INPR_Register, OUTR_Register     data registers
//   cpu_inp, cpu_out, cpu_out_data   INP / OUT execute strobes and AC data
//   cpu_ion, cpu_iof                 interrupt enable / disable strobes
//   cpu_fetch_boundary, cpu_int_ack  interrupt sequencing from control unit
//   fgi, fgo, ien, int_r             flags and interrupt request
//   err_overrun, err_underrun        sticky misuse indicators
// ---------------------------------------------------------------------------
module io_int_ctrl
   import io_int_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dev_in_valid,
   input  logic [DATA_W-1:0] dev_in_data,
   output logic              dev_in_ready,
   output logic              dev_out_valid,
   input  logic              dev_out_ready,
   output logic [DATA_W-1:0] INPR_Register,
   output logic [DATA_W-1:0] OUTR_Register,
   input  logic              cpu_inp,
   input  logic              cpu_out,
   input  logic [DATA_W-1:0] cpu_out_data,
   input  logic              cpu_ion,
   input  logic              cpu_iof,
   input  logic              cpu_fetch_boundary,
   input  logic              cpu_int_ack,
   output logic              fgi,
   output logic              fgo,
   output logic              ien,
   output logic              int_r,
   output logic              err_overrun,
   output logic              err_underrun
);

   in_state_t  in_state;
   out_state_t out_state;

   // Flags and handshake signals are straight decodes of the channel state
   // registers, so nothing combinational reaches them from the inputs.
   assign fgi           = (in_state == IN_FULL);
   assign fgo           = (out_state == OUT_IDLE);
   assign dev_in_ready  = ~fgi;
   assign dev_out_valid = ~fgo;

   // Input channel. A word is only taken while empty, so a device word
   // offered in the same cycle as the INP that empties the register is not
   // accepted; it lands at the earliest on the following cycle. INPR keeps
   // its value across the clear because the CPU samples it alongside cpu_inp.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_state      <= in_state_t'(FGI_RST);
         INPR_Register <= '0;
         err_underrun  <= 1'b0;
      end else begin
         case (in_state)
            IN_EMPTY: begin
               if (cpu_inp) begin
                  err_underrun <= 1'b1;
               end
               if (dev_in_valid) begin
                  INPR_Register <= dev_in_data;
                  in_state      <= IN_FULL;
               end
            end
            IN_FULL: begin
               if (cpu_inp) begin
                  in_state <= IN_EMPTY;
               end
            end
            default: begin
               in_state <= in_state_t'(FGI_RST);
            end
         endcase
      end
   end

   // Output channel. OUTR is only written from idle, so an OUT issued while
   // busy is dropped and flagged even if the device finishes that same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_state     <= out_state_t'(FGO_RST);
         OUTR_Register <= '0;
         err_overrun   <= 1'b0;
      end else begin
         case (out_state)
            OUT_IDLE: begin
               if (cpu_out) begin
                  OUTR_Register <= cpu_out_data;
                  out_state     <= OUT_BUSY;
               end
            end
            OUT_BUSY: begin
               if (cpu_out) begin
                  err_overrun <= 1'b1;
               end
               if (dev_out_ready) begin
                  out_state <= OUT_IDLE;
               end
            end
            default: begin
               out_state <= out_state_t'(FGO_RST);
            end
         endcase
      end
   end

   int_req_fsm u_int_req_fsm (
      .clk      (clk),
      .reset    (reset),
      .ion      (cpu_ion),
      .iof      (cpu_iof),
      .ack      (cpu_int_ack),
      .boundary (cpu_fetch_boundary),
      .flag_any (fgi | fgo),
      .ien      (ien),
      .int_r    (int_r)
   );

endmodule

// File: tb/tb_io_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_int_ctrl
// Directed bench for io_int_ctrl. Inputs change 1 time unit after a rising
// edge and outputs are checked 1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_io_int_ctrl;

   localparam int DATA_W = 16;

   logic              clk;
   logic              reset;
   logic              dev_in_valid;
   logic [DATA_W-1:0] dev_in_data;
   logic              dev_in_ready;
   logic              dev_out_valid;
   logic              dev_out_ready;
   logic [DATA_W-1:0] INPR_Register;
   logic [DATA_W-1:0] OUTR_Register;
   logic              cpu_inp;
   logic              cpu_out;
   logic [DATA_W-1:0] cpu_out_data;
   logic              cpu_ion;
   logic              cpu_iof;
   logic              cpu_fetch_boundary;
   logic              cpu_int_ack;
   logic              fgi;
   logic              fgo;
   logic              ien;
   logic              int_r;
   logic              err_overrun;
   logic              err_underrun;

   int tests_run;
   int fail_count;

   io_int_ctrl #(.DATA_W(DATA_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .dev_in_valid       (dev_in_valid),
      .dev_in_data        (dev_in_data),
      .dev_in_ready       (dev_in_ready),
      .dev_out_valid      (dev_out_valid),
      .dev_out_ready      (dev_out_ready),
      .INPR_Register      (INPR_Register),
      .OUTR_Register      (OUTR_Register),
      .cpu_inp            (cpu_inp),
      .cpu_out            (cpu_out),
      .cpu_out_data       (cpu_out_data),
      .cpu_ion            (cpu_ion),
      .cpu_iof            (cpu_iof),
      .cpu_fetch_boundary (cpu_fetch_boundary),
      .cpu_int_ack        (cpu_int_ack),
      .fgi                (fgi),
      .fgo                (fgo),
      .ien                (ien),
      .int_r              (int_r),
      .err_overrun        (err_overrun),
      .err_underrun       (err_underrun)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({INPR_Register, OUTR_Register} !== 32'h0) begin
         $display("[TB] FAIL reset_regs: got %h/%h expected 0000/0000", INPR_Register, OUTR_Register);
         fail_count++;
      end
      tests_run++;
      if ({fgi, fgo, ien, int_r} !== 4'b0100) begin
         $display("[TB] FAIL reset_flags fgi,fgo,ien,int_r: got %b expected 0100", {fgi, fgo, ien, int_r});
         fail_count++;
      end
      tests_run++;
      if ({dev_in_ready, dev_out_valid, err_overrun, err_underrun} !== 4'b1000) begin
         $display("[TB] FAIL reset_hs_err: got %b expected 1000",
                  {dev_in_ready, dev_out_valid, err_overrun, err_underrun});
         fail_count++;
      end
   endtask

   task automatic test_input_path();
      dev_in_valid = 1'b1;
      dev_in_data  = 16'h00A5;
      step();
      dev_in_valid = 1'b0;
      tests_run++;
      if ({INPR_Register, fgi, dev_in_ready} !== {16'h00A5, 1'b1, 1'b0}) begin
         $display("[TB] FAIL in_load: got INPR=%h fgi=%b rdy=%b expected 00a5 1 0",
                  INPR_Register, fgi, dev_in_ready);
         fail_count++;
      end
      cpu_inp = 1'b1;
      step();
      cpu_inp = 1'b0;
      tests_run++;
      if ({INPR_Register, fgi, dev_in_ready, err_underrun} !== {16'h00A5, 1'b0, 1'b1, 1'b0}) begin
         $display("[TB] FAIL in_consume: got INPR=%h fgi=%b rdy=%b unf=%b expected 00a5 0 1 0",
                  INPR_Register, fgi, dev_in_ready, err_underrun);
         fail_count++;
      end
   endtask

   // A word offered in the clearing cycle must wait one more cycle.
   task automatic test_back_to_back();
      dev_in_valid = 1'b1;
      dev_in_data  = 16'h2222;
      step();
      cpu_inp     = 1'b1;
      dev_in_data = 16'h3333;
      step();
      cpu_inp = 1'b0;
      tests_run++;
      if ({INPR_Register, fgi} !== {16'h2222, 1'b0}) begin
         $display("[TB] FAIL b2b_clear: got INPR=%h fgi=%b expected 2222 0", INPR_Register, fgi);
         fail_count++;
      end
      step();
      dev_in_valid = 1'b0;
      tests_run++;
      if ({INPR_Register, fgi} !== {16'h3333, 1'b1}) begin
         $display("[TB] FAIL b2b_reload: got INPR=%h fgi=%b expected 3333 1", INPR_Register, fgi);
         fail_count++;
      end
      cpu_inp = 1'b1;
      step();
      cpu_inp = 1'b0;
   endtask

   task automatic test_output_and_overrun();
      cpu_out      = 1'b1;
      cpu_out_data = 16'h1234;
      step();
      cpu_out = 1'b0;
      tests_run++;
      if ({OUTR_Register, fgo, dev_out_valid} !== {16'h1234, 1'b0, 1'b1}) begin
         $display("[TB] FAIL out_load: got OUTR=%h fgo=%b vld=%b expected 1234 0 1",
                  OUTR_Register, fgo, dev_out_valid);
         fail_count++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if ({OUTR_Register, fgo} !== {16'h1234, 1'b0}) begin
            $display("[TB] FAIL out_hold%0d: got OUTR=%h fgo=%b expected 1234 0", i, OUTR_Register, fgo);
            fail_count++;
         end
      end
      cpu_out      = 1'b1;
      cpu_out_data = 16'h5678;
      step();
      cpu_out = 1'b0;
      tests_run++;
      if ({OUTR_Register, fgo, err_overrun} !== {16'h1234, 1'b0, 1'b1}) begin
         $display("[TB] FAIL overrun: got OUTR=%h fgo=%b ovr=%b expected 1234 0 1",
                  OUTR_Register, fgo, err_overrun);
         fail_count++;
      end
      dev_out_ready = 1'b1;
      step();
      dev_out_ready = 1'b0;
      tests_run++;
      if ({fgo, dev_out_valid} !== 2'b10) begin
         $display("[TB] FAIL out_done: got fgo,vld=%b expected 10", {fgo, dev_out_valid});
         fail_count++;
      end
      // OUT colliding with completion: handshake ends, new word is dropped
      cpu_out      = 1'b1;
      cpu_out_data = 16'hAAAA;
      step();
      cpu_out_data  = 16'hBBBB;
      dev_out_ready = 1'b1;
      step();
      cpu_out       = 1'b0;
      dev_out_ready = 1'b0;
      tests_run++;
      if ({OUTR_Register, fgo} !== {16'hAAAA, 1'b1}) begin
         $display("[TB] FAIL out_collide: got OUTR=%h fgo=%b expected aaaa 1", OUTR_Register, fgo);
         fail_count++;
      end
   endtask

   task automatic test_underrun();
      tests_run++;
      if (err_underrun !== 1'b0) begin
         $display("[TB] FAIL unf_pre: got %b expected 0", err_underrun);
         fail_count++;
      end
      cpu_inp = 1'b1;
      step();
      cpu_inp = 1'b0;
      tests_run++;
      if ({err_underrun, fgi, INPR_Register} !== {1'b1, 1'b0, 16'h3333}) begin
         $display("[TB] FAIL underrun: got unf=%b fgi=%b INPR=%h expected 1 0 3333",
                  err_underrun, fgi, INPR_Register);
         fail_count++;
      end
   endtask

   task automatic test_interrupt();
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b10) begin
         $display("[TB] FAIL int_arm: got ien,r=%b expected 10", {ien, int_r});
         fail_count++;
      end
      cpu_fetch_boundary = 1'b1;
      step();
      cpu_fetch_boundary = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b11) begin
         $display("[TB] FAIL int_raise: got ien,r=%b expected 11", {ien, int_r});
         fail_count++;
      end
      cpu_int_ack = 1'b1;
      step();
      cpu_int_ack = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b00) begin
         $display("[TB] FAIL int_ack: got ien,r=%b expected 00", {ien, int_r});
         fail_count++;
      end
      cpu_ion = 1'b1;
      step();
      cpu_ion            = 1'b0;
      cpu_fetch_boundary = 1'b1;
      step();
      cpu_fetch_boundary = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b11) begin
         $display("[TB] FAIL int_raise2: got ien,r=%b expected 11", {ien, int_r});
         fail_count++;
      end
      cpu_iof     = 1'b1;
      cpu_int_ack = 1'b1;
      step();
      cpu_iof     = 1'b0;
      cpu_int_ack = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b00) begin
         $display("[TB] FAIL int_iof_ack: got ien,r=%b expected 00", {ien, int_r});
         fail_count++;
      end
      cpu_fetch_boundary = 1'b1;
      step();
      cpu_fetch_boundary = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b00) begin
         $display("[TB] FAIL int_no_rearm: got ien,r=%b expected 00", {ien, int_r});
         fail_count++;
      end
      // IOF from ARMED disables without raising anything
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      cpu_iof = 1'b1;
      step();
      cpu_iof = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b00) begin
         $display("[TB] FAIL int_iof_armed: got ien,r=%b expected 00", {ien, int_r});
         fail_count++;
      end
   endtask

   task automatic test_no_false_interrupt();
      cpu_ion      = 1'b1;
      cpu_out      = 1'b1;
      cpu_out_data = 16'h0F0F;
      step();
      cpu_ion = 1'b0;
      cpu_out = 1'b0;
      tests_run++;
      if ({ien, fgi, fgo} !== 3'b100) begin
         $display("[TB] FAIL nfi_setup ien,fgi,fgo: got %b expected 100", {ien, fgi, fgo});
         fail_count++;
      end
      for (int i = 0; i < 4; i++) begin
         cpu_fetch_boundary = 1'b1;
         step();
         cpu_fetch_boundary = 1'b0;
         tests_run++;
         if (int_r !== 1'b0) begin
            $display("[TB] FAIL nfi_quiet%0d: got int_r=%b expected 0", i, int_r);
            fail_count++;
         end
      end
      // Completion and boundary together: flag was still clear before the edge
      cpu_fetch_boundary = 1'b1;
      dev_out_ready      = 1'b1;
      step();
      cpu_fetch_boundary = 1'b0;
      dev_out_ready      = 1'b0;
      tests_run++;
      if ({fgo, int_r} !== 2'b10) begin
         $display("[TB] FAIL nfi_same_edge fgo,r: got %b expected 10", {fgo, int_r});
         fail_count++;
      end
      cpu_fetch_boundary = 1'b1;
      step();
      cpu_fetch_boundary = 1'b0;
      tests_run++;
      if ({ien, int_r} !== 2'b11) begin
         $display("[TB] FAIL nfi_raise: got ien,r=%b expected 11", {ien, int_r});
         fail_count++;
      end
   endtask

   // Reset lands while a device word is being offered and R is pending.
   task automatic test_reset_mid_transfer();
      cpu_out      = 1'b1;
      cpu_out_data = 16'h7777;
      step();
      cpu_out      = 1'b0;
      dev_in_valid = 1'b1;
      dev_in_data  = 16'hBEEF;
      reset        = 1'b1;
      #12;
      reset        = 1'b0;
      dev_in_valid = 1'b0;
      step();
      tests_run++;
      if ({INPR_Register, OUTR_Register} !== 32'h0) begin
         $display("[TB] FAIL rst_mid_regs: got %h/%h expected 0000/0000", INPR_Register, OUTR_Register);
         fail_count++;
      end
      tests_run++;
      if ({fgi, fgo, dev_in_ready, dev_out_valid, ien, int_r} !== 6'b011000) begin
         $display("[TB] FAIL rst_mid_flags: got %b expected 011000",
                  {fgi, fgo, dev_in_ready, dev_out_valid, ien, int_r});
         fail_count++;
      end
      tests_run++;
      if ({err_overrun, err_underrun} !== 2'b00) begin
         $display("[TB] FAIL rst_mid_err: got %b expected 00", {err_overrun, err_underrun});
         fail_count++;
      end
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      tests_run          = 0;
      fail_count         = 0;
      reset              = 1'b1;
      dev_in_valid       = 1'b0;
      dev_in_data        = '0;
      dev_out_ready      = 1'b0;
      cpu_inp            = 1'b0;
      cpu_out            = 1'b0;
      cpu_out_data       = '0;
      cpu_ion            = 1'b0;
      cpu_iof            = 1'b0;
      cpu_fetch_boundary = 1'b0;
      cpu_int_ack        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      test_reset();
      test_input_path();
      test_back_to_back();
      test_output_and_overrun();
      test_underrun();
      test_interrupt();
      test_no_false_interrupt();
      test_reset_mid_transfer();

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/io_int_ctrl.md
Name: io_int_ctrl

Overview:
- Sequences the CPU's 16-bit I/O datapath: loads INPR_Register from an external input device and drains OUTR_Register to an external output device.
- Maintains the FGI/FGO flags and the IEN interrupt enable.
- Raises the interrupt-cycle request R toward the hardwired control unit.
- Sits between the CPU control unit (instruction-decode strobes) and the external devices, which use valid/ready handshakes.

Parameters:
- DATA_W, 16, width of INPR/OUTR data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- dev_in_valid  in  1  input device offers a word
- dev_in_data  in  DATA_W  input device word
- dev_in_ready  out  1  controller accepts an input word (= ~FGI)
- dev_out_valid  out  1  OUTR holds an undelivered word (= ~FGO)
- dev_out_ready  in  1  output device consumes the word
- INPR_Register  out  DATA_W  input register to the CPU AC path
- OUTR_Register  out  DATA_W  output register to the device
- cpu_inp  in  1  INP instruction execute strobe (1 cycle)
- cpu_out  in  1  OUT instruction execute strobe (1 cycle)
- cpu_out_data  in  DATA_W  AC value for OUT (low bits used)
- cpu_ion  in  1  ION strobe
- cpu_iof  in  1  IOF strobe
- cpu_fetch_boundary  in  1  pulse at the T0 slot before the next fetch
- cpu_int_ack  in  1  interrupt cycle completed (R/IEN cleared)
- fgi  out  1  input flag (SKI test)
- fgo  out  1  output flag (SKO test)
- ien  out  1  interrupt enable
- int_r  out  1  interrupt-cycle request R
- err_overrun  out  1  sticky: OUT issued while FGO=0
- err_underrun  out  1  sticky: INP issued while FGI=0

Behaviour:
- Reset values:
  - INPR_Register=0, OUTR_Register=0
  - fgi=0, fgo=1, ien=0, int_r=0
  - err_overrun=0, err_underrun=0
  - FSMs in IN_EMPTY / OUT_IDLE / INT_OFF
- Reset mid-handshake: state is discarded immediately (async), and the in-flight word is dropped.
- Input channel FSM:
  - IN_EMPTY (fgi=0): dev_in_ready=1. On dev_in_valid, latch dev_in_data into INPR_Register, set fgi=1 next edge, and go to IN_FULL.
  - IN_FULL (fgi=1): dev_in_ready=0. On cpu_inp, set fgi=0 next edge and go to IN_EMPTY. INPR_Register holds its value (the CPU samples it in the same cycle as cpu_inp).
  - cpu_inp in IN_EMPTY: no state change; set err_underrun.
  - A device word cannot land in the cycle cpu_inp clears the flag, because ready is 0 in that cycle. A new word is accepted at the earliest one cycle after the clear.
- Output channel FSM:
  - OUT_IDLE (fgo=1): dev_out_valid=0. On cpu_out, OUTR_Register=cpu_out_data[DATA_W-1:0], set fgo=0, and go to OUT_BUSY.
  - OUT_BUSY (fgo=0): dev_out_valid=1 and OUTR_Register is stable. On dev_out_ready, set fgo=1 and go to OUT_IDLE.
  - cpu_out in OUT_BUSY is ignored (OUTR unchanged); set err_overrun.
  - cpu_out and dev_out_ready in the same cycle in OUT_BUSY: the handshake completes and the OUT is treated as overrun (ignored).
- Interrupt FSM:
  - INT_OFF (ien=0): cpu_ion goes to INT_ARMED.
  - INT_ARMED (ien=1):
    - cpu_iof goes to INT_OFF.
    - cpu_fetch_boundary && (fgi||fgo) goes to INT_PENDING with int_r=1.
  - INT_PENDING (int_r=1, ien=1):
    - cpu_int_ack goes to INT_OFF (int_r=0, ien=0).
    - cpu_iof goes to INT_OFF with int_r=0.
  - Priority: cpu_int_ack > cpu_iof > cpu_ion > cpu_fetch_boundary.
  - The flag test uses flag values registered before the edge.
- Latency:
  - All flag/state updates appear one clock after the causing strobe or handshake.
  - fgi, fgo, dev_in_ready and dev_out_valid are direct register decodes; there are no combinational paths from inputs.
- Error flags are cleared only by reset.

Decomposition:
- Shared package io_int_pkg holds:
  - state encodings for IN_EMPTY/IN_FULL, OUT_IDLE/OUT_BUSY, INT_OFF/INT_ARMED/INT_PENDING
  - the reset constants FGO_RST=1 and FGI_RST=0
- One sub-module, int_req_fsm: the three-state interrupt FSM with inputs ion, iof, ack, boundary, flag_any and outputs ien, int_r.
- The I/O channels stay inline in io_int_ctrl.

Test Plan:
- Reset mid-transfer: drive dev_in_valid=1 with 0xBEEF, assert reset for 1.2 cycles, then hold dev_in_valid=0 after release → INPR=0, fgi=0, fgo=1, dev_in_ready=1, int_r=0.
- Input path: dev_in_valid=1 with 0x00A5 for 1 cycle → INPR=0x00A5, fgi=1, dev_in_ready=0 next cycle. Then cpu_inp pulse → fgi=0 one cycle later, and INPR stays 0x00A5.
- Output path: cpu_out with 0x1234 → OUTR=0x1234, fgo=0, dev_out_valid=1. Hold dev_out_ready=0 for 3 cycles → OUTR stable. dev_out_ready=1 → fgo=1.
- Overrun: while OUT_BUSY with 0x1234, cpu_out with 0x5678 → OUTR stays 0x1234 and err_overrun=1. Underrun: cpu_inp with fgi=0 → err_underrun=1.
- Interrupt: cpu_ion, then cpu_fetch_boundary with fgo=1 → int_r=1 next cycle. cpu_int_ack → int_r=0, ien=0. Repeat with cpu_iof and cpu_int_ack in the same cycle → both cleared, no re-arm.
- No false interrupt: ien=1, fgi=0 and fgo=0 (OUT_BUSY), cpu_fetch_boundary pulses ×4 → int_r stays 0. Device completes (fgo=1), then next boundary → int_r=1.
